// File: rtl/rf_config_frame_engine.sv
// rf_config_frame_engine
//   Configuration/command engine for the RF transceiver. While the MCU holds the
//   module in configuration mode, it parses UART byte frames and keeps the active
//   and persisted configuration images. It also produces echo, return-config and
//   version responses, plus a soft-reset request.
//
//   Frames:
//     HEAD_SAVE/HEAD_TEMP + CFG_BYTES payload  -> commit config, echo the frame
//     RET_CONFIG_CMD x3                        -> HEAD_SAVE + saved_config bytes
//     RET_VERSION_CMD x3                       -> VERSION_WORD bytes, MSB first
//     RESET_CMD x3                             -> soft_reset pulse, config <= saved
//
// Ports:
//   internal_clk, rst_n    clock, asynchronous active-low reset
//   cfg_mode_en            configuration mode (M1 & M0)
//   rx_data, rx_valid      byte strobe from the MCU UART receiver
//   tx_data, tx_valid,     response byte handshake to the MCU UART transmitter
//   tx_ready
//   config_out             active configuration image (byte0 = MSB)
//   saved_config           persisted configuration image
//   sped_out               SPED byte of config_out
//   busy                   high whenever the engine is not idle
//   soft_reset             one-cycle soft-reset request
//   frame_error            one-cycle pulse on a malformed, timed-out or aborted frame
module rf_config_frame_engine #(
   parameter int                                DATA_WIDTH       = 8,
   parameter int                                CFG_BYTES        = 5,
   parameter logic [CFG_BYTES*DATA_WIDTH-1:0]   DEFAULT_CONFIG   = 40'h00001A1744,
   parameter int                                SPED_INDEX       = 2,
   parameter logic [DATA_WIDTH-1:0]             HEAD_SAVE        = 8'hC0,
   parameter logic [DATA_WIDTH-1:0]             HEAD_TEMP        = 8'hC2,
   parameter logic [DATA_WIDTH-1:0]             RET_CONFIG_CMD   = 8'hC1,
   parameter logic [DATA_WIDTH-1:0]             RET_VERSION_CMD  = 8'hC3,
   parameter logic [DATA_WIDTH-1:0]             RESET_CMD        = 8'hC4,
   parameter logic [31:0]                       VERSION_WORD     = 32'hC3322702,
   parameter int                                BYTE_TIMEOUT_CLK = 500000
) (
   input  logic                                internal_clk,
   input  logic                                rst_n,
   input  logic                                cfg_mode_en,
   input  logic [DATA_WIDTH-1:0]               rx_data,
   input  logic                                rx_valid,
   output logic [DATA_WIDTH-1:0]               tx_data,
   output logic                                tx_valid,
   input  logic                                tx_ready,
   output logic [CFG_BYTES*DATA_WIDTH-1:0]     config_out,
   output logic [CFG_BYTES*DATA_WIDTH-1:0]     saved_config,
   output logic [DATA_WIDTH-1:0]               sped_out,
   output logic                                busy,
   output logic                                soft_reset,
   output logic                                frame_error
);

   localparam int CW        = CFG_BYTES*DATA_WIDTH;
   localparam int VER_BYTES = 32/DATA_WIDTH;
   // Response buffer must hold the longer of the echo/return-config and version replies.
   localparam int TX_MAX    = (CFG_BYTES+1 > VER_BYTES) ? CFG_BYTES+1 : VER_BYTES;
   localparam int CNT_W     = $clog2(TX_MAX+1);
   localparam int TO_W      = (BYTE_TIMEOUT_CLK > 2) ? $clog2(BYTE_TIMEOUT_CLK) : 1;

   localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_CFG = CNT_W'(CFG_BYTES-1);
   localparam logic [CNT_W-1:0] LAST_CRS = CNT_W'(CFG_BYTES);
   localparam logic [CNT_W-1:0] LAST_VER = CNT_W'(VER_BYTES-1);
   localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BYTE_TIMEOUT_CLK-1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT_CFG, S_COLLECT_CMD, S_RESPOND} state_t;

   state_t                r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_head, r_code;
   logic [CNT_W-1:0]      r_idx;
   logic [1:0]            r_rep;
   logic [CW-1:0]         r_shadow, r_cfg, r_saved;
   logic [TO_W-1:0]       r_to_cnt;
   // [0]: frame complete (commit/load next), [1]: response loaded (enter RESPOND next)
   logic [1:0]            r_vld_pipe;
   logic [DATA_WIDTH-1:0] r_tx_buf [TX_MAX];
   logic [CNT_W-1:0]      r_tx_idx, r_tx_last;
   logic                  r_frame_err, r_soft_rst;

   logic w_is_head, w_is_cmd, w_ferr, w_start_cfg, w_start_cmd;
   logic w_cfg_wr, w_cmd_ok, w_done, w_tx_acc, w_reset_frame;

   assign w_is_head     = (rx_data == HEAD_SAVE) || (rx_data == HEAD_TEMP);
   assign w_is_cmd      = (rx_data == RET_CONFIG_CMD) || (rx_data == RET_VERSION_CMD) ||
                          (rx_data == RESET_CMD);
   assign w_tx_acc      = tx_valid & tx_ready;
   assign w_reset_frame = (r_state == S_COLLECT_CMD) && (r_code == RESET_CMD);

   always_ff @(posedge internal_clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ferr      = 1'b0;
      w_start_cfg = 1'b0;
      w_start_cmd = 1'b0;
      w_cfg_wr    = 1'b0;
      w_cmd_ok    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cfg_mode_en && rx_valid) begin
               if (w_is_head) begin
                  w_start_cfg = 1'b1;
                  w_state_nxt = S_COLLECT_CFG;
               end else if (w_is_cmd) begin
                  w_start_cmd = 1'b1;
                  w_state_nxt = S_COLLECT_CMD;
               end else begin
                  w_ferr = 1'b1;
               end
            end
         end
         S_COLLECT_CFG, S_COLLECT_CMD: begin
            // Once the frame is complete it is no longer abortable; input is ignored
            // for the two commit/load cycles.
            if (r_vld_pipe[1]) begin
               w_state_nxt = S_RESPOND;
            end else if (r_vld_pipe[0]) begin
               if (w_reset_frame) w_state_nxt = S_IDLE;
            end else if (!cfg_mode_en) begin
               w_ferr      = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (rx_valid) begin
               // A byte arriving on the timeout cycle takes priority over expiry.
               if (r_state == S_COLLECT_CFG) begin
                  w_cfg_wr = 1'b1;
                  w_done   = (r_idx == LAST_CFG);
               end else if (rx_data != r_code) begin
                  w_ferr      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cmd_ok = 1'b1;
                  w_done   = (r_rep == 2'd2);
               end
            end else if (r_to_cnt == TO_LAST) begin
               w_ferr      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_RESPOND: begin
            if (w_tx_acc && (r_tx_idx == r_tx_last)) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge internal_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head      <= '0;
         r_code      <= '0;
         r_idx       <= '0;
         r_rep       <= '0;
         r_shadow    <= '0;
         r_cfg       <= DEFAULT_CONFIG;
         r_saved     <= DEFAULT_CONFIG;
         r_to_cnt    <= '0;
         r_vld_pipe  <= '0;
         r_tx_idx    <= '0;
         r_tx_last   <= '0;
         r_frame_err <= 1'b0;
         r_soft_rst  <= 1'b0;
         for (int i = 0; i < TX_MAX; i++) r_tx_buf[i] <= '0;
      end else begin
         r_frame_err <= w_ferr;
         r_soft_rst  <= 1'b0;
         r_vld_pipe  <= {r_vld_pipe[0] & ~w_reset_frame, w_done};

         if (w_start_cfg) begin
            r_head <= rx_data;
            r_idx  <= '0;
         end
         if (w_start_cmd) begin
            r_code <= rx_data;
            r_rep  <= 2'd1;
         end
         if (w_cfg_wr) begin
            for (int i = 0; i < CFG_BYTES; i++)
               if (r_idx == CNT_W'(i))
                  r_shadow[(CFG_BYTES-1-i)*DATA_WIDTH +: DATA_WIDTH] <= rx_data;
            r_idx <= r_idx + C_ONE;
         end
         if (w_cmd_ok) r_rep <= r_rep + 2'd1;

         // Commit / response-load stage, one cycle after the final frame byte.
         if (r_vld_pipe[0]) begin
            r_tx_idx <= '0;
            if (r_state == S_COLLECT_CFG) begin
               r_cfg <= r_shadow;
               if (r_head == HEAD_SAVE) r_saved <= r_shadow;
               r_tx_buf[0] <= r_head;
               for (int i = 0; i < CFG_BYTES; i++)
                  r_tx_buf[i+1] <= r_shadow[(CFG_BYTES-1-i)*DATA_WIDTH +: DATA_WIDTH];
               r_tx_last <= LAST_CRS;
            end else if (r_code == RET_CONFIG_CMD) begin
               r_tx_buf[0] <= HEAD_SAVE;
               for (int i = 0; i < CFG_BYTES; i++)
                  r_tx_buf[i+1] <= r_saved[(CFG_BYTES-1-i)*DATA_WIDTH +: DATA_WIDTH];
               r_tx_last <= LAST_CRS;
            end else if (r_code == RET_VERSION_CMD) begin
               for (int i = 0; i < VER_BYTES; i++)
                  r_tx_buf[i] <= VERSION_WORD[(VER_BYTES-1-i)*DATA_WIDTH +: DATA_WIDTH];
               r_tx_last <= LAST_VER;
            end else begin
               r_soft_rst <= 1'b1;
               r_cfg      <= r_saved;
            end
         end else if (w_tx_acc) begin
            r_tx_idx <= r_tx_idx + C_ONE;
         end

         // Inter-byte timer: runs only while collecting, saturates at the limit.
         if (rx_valid || (r_state == S_IDLE) || (r_state == S_RESPOND))
            r_to_cnt <= '0;
         else if (r_to_cnt != TO_LAST)
            r_to_cnt <= r_to_cnt + TO_ONE;
      end
   end

   assign tx_valid     = (r_state == S_RESPOND);
   assign tx_data      = tx_valid ? r_tx_buf[r_tx_idx] : '0;
   assign config_out   = r_cfg;
   assign saved_config = r_saved;
   assign sped_out     = r_cfg[(CFG_BYTES-1-SPED_INDEX)*DATA_WIDTH +: DATA_WIDTH];
   assign busy         = (r_state != S_IDLE);
   assign soft_reset   = r_soft_rst;
   assign frame_error  = r_frame_err;

endmodule

// File: tb/tb_rf_config_frame_engine.sv
// Directed testbench for rf_config_frame_engine. The inter-byte timeout is
// shortened to 40 clocks so the boundary cases run quickly.
module tb_rf_config_frame_engine;

   localparam int TO = 40;
   localparam logic [39:0] DEF = 40'h00001A1744;

   logic        internal_clk = 1'b0;
   logic        rst_n        = 1'b0;
   logic        cfg_mode_en  = 1'b0;
   logic [7:0]  rx_data      = '0;
   logic        rx_valid     = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready     = 1'b0;
   logic [39:0] config_out, saved_config;
   logic [7:0]  sped_out;
   logic        busy, soft_reset, frame_error;

   int checks = 0;
   int errors = 0;

   rf_config_frame_engine #(.BYTE_TIMEOUT_CLK(TO)) dut (
      .internal_clk(internal_clk), .rst_n(rst_n), .cfg_mode_en(cfg_mode_en),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .config_out(config_out), .saved_config(saved_config), .sped_out(sped_out),
      .busy(busy), .soft_reset(soft_reset), .frame_error(frame_error)
   );

   always #5 internal_clk = ~internal_clk;

   task automatic tick();
      @(posedge internal_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_tx(input string name);
      int c = 0;
      while (!tx_valid && c < 20) begin
         tick();
         c++;
      end
      checks++;
      if (tx_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s: tx_valid never rose (got %b, need 1)", name, tx_valid);
      end
   endtask

   // Drain n response bytes; byte i is exp[(n-1-i)*8 +: 8]. With toggle set,
   // tx_ready alternates starting low, and an unaccepted byte must stay put.
   task automatic collect(input string name, input logic [47:0] exp, input int n,
                          input bit toggle);
      int got = 0;
      int cyc = 0;
      bit held = 0;
      logic [7:0] prev = '0;
      while (got < n && cyc < 100) begin
         tx_ready = toggle ? cyc[0] : 1'b1;
         if (held) begin
            checks++;
            if (tx_data !== prev) begin
               errors++;
               $display("FAIL %s hold: tx_data %h, need %h", name, tx_data, prev);
            end
         end
         held = tx_valid && !tx_ready;
         prev = tx_data;
         if (tx_valid && tx_ready) begin
            checks++;
            if (tx_data !== exp[(n-1-got)*8 +: 8]) begin
               errors++;
               $display("FAIL %s byte%0d: tx_data %h, need %h", name, got, tx_data,
                        exp[(n-1-got)*8 +: 8]);
            end
            got++;
         end
         tick();
         cyc++;
      end
      tx_ready = 1'b0;
      checks++;
      if (got != n || tx_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s end: got %0d bytes tx_valid %b busy %b, need %0d/0/0",
                  name, got, tx_valid, busy, n);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (config_out !== DEF || saved_config !== DEF || tx_valid !== 1'b0 ||
          tx_data !== 8'h00 || busy !== 1'b0 || soft_reset !== 1'b0 || frame_error !== 1'b0) begin
         errors++;
         $display("FAIL reset: cfg %h saved %h txv %b txd %h busy %b sr %b fe %b, need %h %h 0 00 0 0 0",
                  config_out, saved_config, tx_valid, tx_data, busy, soft_reset, frame_error, DEF, DEF);
      end
   endtask

   task automatic test_temp_cfg();
      logic [7:0] f [6];
      f = '{8'hC2, 8'h00, 8'h01, 8'h1D, 8'h17, 8'h44};
      cfg_mode_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send_byte(f[i]);
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL temp busy byte%0d: %b, need 1", i, busy);
         end
      end
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL temp lat0: tx_valid %b, need 0", tx_valid); end
      tick();
      checks++;
      if (tx_valid !== 1'b0 || config_out !== 40'h00011D1744 || sped_out !== 8'h1D ||
          saved_config !== DEF) begin
         errors++;
         $display("FAIL temp commit: txv %b cfg %h sped %h saved %h, need 0 00011d1744 1d %h",
                  tx_valid, config_out, sped_out, saved_config, DEF);
      end
      tick();
      checks++;
      if (tx_valid !== 1'b1) begin errors++; $display("FAIL temp lat2: tx_valid %b, need 1", tx_valid); end
      collect("temp echo", 48'hC200011D1744, 6, 1'b0);
   endtask

   task automatic test_save_return();
      logic [7:0] f [6];
      f = '{8'hC0, 8'h12, 8'h34, 8'h1A, 8'h06, 8'h44};
      for (int i = 0; i < 6; i++) send_byte(f[i]);
      wait_tx("save");
      collect("save echo", 48'hC012341A0644, 6, 1'b0);
      checks++;
      if (saved_config !== 40'h12341A0644 || config_out !== 40'h12341A0644) begin
         errors++;
         $display("FAIL save image: saved %h cfg %h, need 12341a0644", saved_config, config_out);
      end
      for (int i = 0; i < 3; i++) send_byte(8'hC1);
      wait_tx("retcfg");
      collect("retcfg", 48'hC012341A0644, 6, 1'b1);
   endtask

   task automatic test_version();
      for (int i = 0; i < 3; i++) send_byte(8'hC3);
      wait_tx("version");
      collect("version", 48'h0000C3322702, 4, 1'b0);
      send_byte(8'hC3);
      send_byte(8'hC3);
      send_byte(8'h55);
      checks++;
      if (frame_error !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL cmd mismatch: fe %b busy %b, need 1 0", frame_error, busy);
      end
      tick();
      checks++;
      if (frame_error !== 1'b0 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL cmd mismatch after: fe %b txv %b, need 0 0", frame_error, tx_valid);
      end
   endtask

   task automatic test_timeout();
      send_byte(8'hC2); send_byte(8'hAA); send_byte(8'hBB);
      for (int i = 0; i < TO-1; i++) tick();
      checks++;
      if (frame_error !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout early: fe %b busy %b, need 0 1", frame_error, busy);
      end
      tick();
      checks++;
      if (frame_error !== 1'b1 || busy !== 1'b0 || config_out !== 40'h12341A0644) begin
         errors++;
         $display("FAIL timeout: fe %b busy %b cfg %h, need 1 0 12341a0644",
                  frame_error, busy, config_out);
      end
      send_byte(8'hC2); send_byte(8'hAA); send_byte(8'hBB);
      for (int i = 0; i < TO-1; i++) tick();
      send_byte(8'hCC);
      checks++;
      if (frame_error !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout edge byte: fe %b busy %b, need 0 1", frame_error, busy);
      end
      send_byte(8'hDD); send_byte(8'hEE);
      wait_tx("timeout edge");
      collect("timeout edge echo", 48'hC2AABBCCDDEE, 6, 1'b0);
      checks++;
      if (config_out !== 40'hAABBCCDDEE) begin
         errors++;
         $display("FAIL timeout edge cfg: %h, need aabbccddee", config_out);
      end
   endtask

   task automatic test_soft_reset();
      logic [7:0] f [6];
      f = '{8'hC2, 8'h01, 8'h02, 8'h1C, 8'h04, 8'h44};
      do_reset();
      for (int i = 0; i < 6; i++) send_byte(f[i]);
      wait_tx("sr cfg");
      collect("sr echo", 48'hC201021C0444, 6, 1'b0);
      checks++;
      if (config_out !== 40'h01021C0444) begin
         errors++;
         $display("FAIL sr cfg: %h, need 01021c0444", config_out);
      end
      for (int i = 0; i < 3; i++) send_byte(8'hC4);
      checks++;
      if (soft_reset !== 1'b0) begin errors++; $display("FAIL sr early: %b, need 0", soft_reset); end
      tick();
      checks++;
      if (soft_reset !== 1'b1 || config_out !== DEF || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL sr pulse: sr %b cfg %h txv %b, need 1 %h 0", soft_reset, config_out, tx_valid, DEF);
      end
      tick();
      checks++;
      if (soft_reset !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL sr after: sr %b busy %b, need 0 0", soft_reset, busy);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (tx_valid !== 1'b0) begin errors++; $display("FAIL sr no resp: txv %b, need 0", tx_valid); end
      end
   endtask

   task automatic test_mode_and_reset();
      cfg_mode_en = 1'b0;
      send_byte(8'hC0);
      checks++;
      if (busy !== 1'b0 || frame_error !== 1'b0) begin
         errors++;
         $display("FAIL mode off: busy %b fe %b, need 0 0", busy, frame_error);
      end
      cfg_mode_en = 1'b1;
      send_byte(8'hC0);
      send_byte(8'h12);
      cfg_mode_en = 1'b0;
      tick();
      checks++;
      if (frame_error !== 1'b1 || busy !== 1'b0 || config_out !== DEF) begin
         errors++;
         $display("FAIL abort: fe %b busy %b cfg %h, need 1 0 %h", frame_error, busy, config_out, DEF);
      end
      cfg_mode_en = 1'b1;
      send_byte(8'hC2); send_byte(8'h01); send_byte(8'h02);
      send_byte(8'h1C); send_byte(8'h04); send_byte(8'h44);
      wait_tx("rst mid");
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || config_out !== DEF || saved_config !== DEF) begin
         errors++;
         $display("FAIL rst mid resp: txv %b busy %b cfg %h saved %h, need 0 0 %h %h",
                  tx_valid, busy, config_out, saved_config, DEF, DEF);
      end
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_temp_cfg();
      test_save_return();
      test_version();
      test_timeout();
      test_soft_reset();
      test_mode_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_config_frame_engine.md
Name: rf_config_frame_engine

Overview:
Parametrised configuration/command engine for the RF transceiver, replacing the fixed-length config handling in the controller. It parses byte frames from the MCU-side UART while in configuration mode (M1=M0=1) and maintains the active and saved configuration images. It generates echo, return-config and version responses to the MCU UART, and a soft-reset request. Configuration length, command codes, version word and inter-byte timeout are all generics.

Parameters:
DATA_WIDTH, 8, byte width of UART data
CFG_BYTES, 5, number of payload bytes following a C0/C2 head (ADDH, ADDL, SPED, CHAN, OPTION)
DEFAULT_CONFIG, 40'h00001A1744, reset image {byte0..byteN-1}; byte0 is the MSB; width = CFG_BYTES*DATA_WIDTH
SPED_INDEX, 2, byte index of the SPED field inside the config image
HEAD_SAVE, 8'hC0, head: load and persist config
HEAD_TEMP, 8'hC2, head: load volatile config
RET_CONFIG_CMD, 8'hC1, return-config command byte
RET_VERSION_CMD, 8'hC3, return-version command byte
RESET_CMD, 8'hC4, soft-reset command byte
VERSION_WORD, 32'hC3322702, version bytes, sent MSB first
BYTE_TIMEOUT_CLK, 500000, maximum idle clocks between bytes of one frame

Ports:
internal_clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_mode_en  in  1  1 = configuration mode (M1_sync & M0_sync)
rx_data  in  DATA_WIDTH  byte from MCU UART receiver
rx_valid  in  1  one-cycle strobe: rx_data valid
tx_data  out  DATA_WIDTH  response byte to MCU UART transmitter
tx_valid  out  1  response byte pending
tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready
config_out  out  CFG_BYTES*DATA_WIDTH  active configuration image
saved_config  out  CFG_BYTES*DATA_WIDTH  persisted configuration image
sped_out  out  DATA_WIDTH  config_out byte SPED_INDEX (combinational)
busy  out  1  1 whenever state != IDLE; feeds AUX (AUX = ~busy)
soft_reset  out  1  one-cycle pulse on a valid reset command
frame_error  out  1  one-cycle pulse on a malformed, timed-out or aborted frame

Behaviour:
- Reset: config_out = saved_config = DEFAULT_CONFIG. tx_valid, tx_data, busy, soft_reset, frame_error = 0. State IDLE, all counters 0.
- States: IDLE, COLLECT_CFG, COLLECT_CMD, RESPOND.
- IDLE: rx_valid ignored unless cfg_mode_en=1.
  - Byte is HEAD_SAVE/HEAD_TEMP: latch head, idx=0, go COLLECT_CFG.
  - Byte is C1/C3/C4 code: latch code, rep=1, go COLLECT_CMD.
  - Any other byte: frame_error pulse, stay IDLE.
- COLLECT_CFG: each rx_valid writes shadow[idx], idx++.
  - On byte CFG_BYTES-1, the next cycle commits config_out <= shadow; HEAD_SAVE also commits saved_config.
  - Response loaded: head byte, then the CFG_BYTES new bytes. Go RESPOND.
- COLLECT_CMD: next two bytes must equal the latched code.
  - Mismatch: frame_error, go IDLE, no action.
  - Third matching byte, RET_CONFIG_CMD: response HEAD_SAVE + saved_config bytes (CFG_BYTES+1 bytes).
  - Third matching byte, RET_VERSION_CMD: response is the 4 VERSION_WORD bytes.
  - Third matching byte, RESET_CMD: soft_reset pulse, config_out <= saved_config, go IDLE with no response.
- Timeout: counter clears on every rx_valid and counts in COLLECT_*. Reaching BYTE_TIMEOUT_CLK-1 gives frame_error and IDLE; shadow is discarded and config is unchanged.
- cfg_mode_en falling while in COLLECT_*: abort, frame_error, IDLE, config unchanged.
- RESPOND:
  - tx_valid=1 and tx_data=current byte, stable until accepted. Advance on tx_valid & tx_ready.
  - After the last byte, tx_valid drops next cycle; go IDLE.
  - Always completes, even if cfg_mode_en drops. rx_valid is ignored during RESPOND, with no error.
- Latency: rx_valid of the final frame byte -> tx_valid=1 is exactly 2 cycles (commit, then load).
- Simultaneous timeout expiry and rx_valid: rx_valid wins and the byte is accepted.
- Reset asserted mid-frame or mid-response: immediate return to reset values; the partial frame is lost.
- Byte counter widths are ceil(log2(CFG_BYTES+2)). No wrap is possible because the count is bounded by frame length.

Test Plan:
- C2 00 01 1D 17 44 in cfg mode -> config_out=40'h00011D1744, sped_out=8'h1D, saved_config unchanged; echo C2 00 01 1D 17 44 with tx_ready held 1; busy high throughout.
- C0 12 34 1A 06 44, then C1 C1 C1 -> saved_config=40'h12341A0644; return stream C0 12 34 1A 06 44; tx_ready toggled every other cycle, each byte held until accepted.
- C3 C3 C3 -> tx stream C3 32 27 02. Then C3 C3 55 -> frame_error pulse, no response.
- C2 AA BB, then 500000 idle clocks -> frame_error, config_out unchanged, busy=0. Repeat with rx_valid at cycle 499999 -> byte accepted, no error.
- C2 01 02 1C 04 44, then C4 C4 C4 -> soft_reset single pulse, config_out reverts to DEFAULT_CONFIG (saved_config), no tx_valid.
- cfg_mode_en=0 with byte C0 -> ignored, busy=0. cfg_mode_en drops after C0 12 -> frame_error, IDLE. rst_n low mid-response -> tx_valid=0 immediately, config=DEFAULT.
